// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: key debounce, run/pause/lap/clear FSM and 100 ms tick scheduler.
// Optional long-press clear on the lap key is enabled by defining LONG_PRESS_CLR_EN.
module stopwatch_ctrl #(
    parameter int unsigned DB_CYCLES   = 500000,
    parameter int unsigned TICK_DIV    = 5000000,
    parameter int unsigned LONG_CYCLES = 100000000
) (
    input  logic       clk_50M,
    input  logic       rst,
    input  logic       key_start_n,
    input  logic       key_lap_n,
    output logic       tick_100ms,
    output logic       cnt_clr,
    output logic       lap_load,
    output logic       disp_sel,
    output logic       running,
    output logic [2:0] state
);

    localparam int unsigned DBW = $clog2(DB_CYCLES);
    localparam int unsigned PW  = $clog2(TICK_DIV);
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [PW-1:0]  PRESC_LAST = PW'(TICK_DIV - 1);
    localparam int unsigned K_START = 0;
    localparam int unsigned K_LAP   = 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_PAUSE = 3'd2,
        S_LAP   = 3'd3
    } state_t;

    logic [1:0]     w_key_raw;
    logic [1:0]     r_sync1;
    logic [1:0]     r_sync2;
    logic [1:0]     r_acc;
    logic [1:0]     r_evt;
    logic [DBW-1:0] r_db_cnt [2];

    state_t         r_state;
    state_t         w_state_nxt;
    logic           w_clr_nxt;
    logic           w_load_nxt;
    logic           w_start;
    logic           w_lap;
    logic           w_long_hit;
    logic           w_run_now;
    logic           w_run_nxt;

    logic [PW-1:0]  r_presc;
    logic [PW-1:0]  w_presc_nxt;
    logic           w_tick_nxt;
    logic           r_tick;
    logic           r_cnt_clr;
    logic           r_lap_load;

    assign w_key_raw = {key_lap_n, key_start_n};

    // Event fires on the same edge that accepts a low level, so it is already a registered pulse.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_acc   <= '1;
            r_evt   <= '0;
            for (int unsigned k = 0; k < 2; k++) begin
                r_db_cnt[k] <= '0;
            end
        end else begin
            r_sync1 <= w_key_raw;
            r_sync2 <= r_sync1;
            for (int unsigned k = 0; k < 2; k++) begin
                r_evt[k] <= 1'b0;
                if (r_sync2[k] != r_acc[k]) begin
                    if (r_db_cnt[k] == DB_LAST) begin
                        r_acc[k]    <= r_sync2[k];
                        r_db_cnt[k] <= '0;
                        r_evt[k]    <= ~r_sync2[k];
                    end else begin
                        r_db_cnt[k] <= r_db_cnt[k] + DBW'(1);
                    end
                end else begin
                    r_db_cnt[k] <= '0;
                end
            end
        end
    end

    assign w_start = r_evt[K_START];
    assign w_lap   = r_evt[K_LAP];

`ifdef LONG_PRESS_CLR_EN
    localparam int unsigned LW = $clog2(LONG_CYCLES + 1);
    localparam logic [LW-1:0] LONG_LAST = LW'(LONG_CYCLES - 1);
    localparam logic [LW-1:0] LONG_SAT  = LW'(LONG_CYCLES);

    logic [LW-1:0] r_long_cnt;

    // Saturating at LONG_CYCLES makes the hit condition true for exactly one cycle per hold.
    always_ff @(posedge clk_50M) begin
        if (rst || r_acc[K_LAP]) begin
            r_long_cnt <= '0;
        end else if (r_long_cnt != LONG_SAT) begin
            r_long_cnt <= r_long_cnt + LW'(1);
        end
    end

    assign w_long_hit = ~r_acc[K_LAP] && (r_long_cnt == LONG_LAST);
`else
    // Never true for a legal LONG_CYCLES; keeps the parameter referenced.
    assign w_long_hit = (LONG_CYCLES == 0);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_clr_nxt   = 1'b0;
        w_load_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN, S_LAP: begin
                if (w_start) begin
                    w_state_nxt = S_PAUSE;
                end else if (w_lap) begin
                    w_state_nxt = S_LAP;
                    w_load_nxt  = 1'b1;
                end
            end
            S_PAUSE: begin
                if (w_start) begin
                    w_state_nxt = S_RUN;
                end else if (w_lap) begin
                    w_state_nxt = S_IDLE;
                    w_clr_nxt   = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_long_hit) begin
            w_state_nxt = S_IDLE;
            w_clr_nxt   = 1'b1;
            w_load_nxt  = 1'b0;
        end
    end

    assign w_run_now = (r_state == S_RUN) || (r_state == S_LAP);
    assign w_run_nxt = (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);

    // Counting only while running now and next suppresses the tick on the leaving edge.
    always_comb begin
        w_presc_nxt = r_presc;
        w_tick_nxt  = 1'b0;
        if ((r_state == S_IDLE) || w_clr_nxt) begin
            w_presc_nxt = '0;
        end else if (w_run_now && w_run_nxt) begin
            if (r_presc == PRESC_LAST) begin
                w_presc_nxt = '0;
                w_tick_nxt  = 1'b1;
            end else begin
                w_presc_nxt = r_presc + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_presc    <= '0;
            r_tick     <= 1'b0;
            r_cnt_clr  <= 1'b0;
            r_lap_load <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_presc    <= w_presc_nxt;
            r_tick     <= w_tick_nxt;
            r_cnt_clr  <= w_clr_nxt;
            r_lap_load <= w_load_nxt;
        end
    end

    assign tick_100ms = r_tick;
    assign cnt_clr    = r_cnt_clr;
    assign lap_load   = r_lap_load;
    assign disp_sel   = (r_state == S_LAP);
    assign running    = w_run_now;
    assign state      = r_state;

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Control/sequencing block for the DE1 stopwatch datapath (min/sec/100 ms counters, lap hold registers, 7-segment decoders).
- Debounces the two pushbuttons and runs the run/pause/lap/clear state machine.
- Issues the 100 ms count-enable tick, the counter clear, the lap-capture strobe and the display select.
- Replaces the edge-clocked button toggles and gated clock chain with a single-clock, enable-based scheduler.

Parameters:
- DB_CYCLES, 500000, consecutive stable cycles before a key level is accepted (10 ms at 50 MHz); minimum 2.
- TICK_DIV, 5000000, clk_50M cycles per tick_100ms pulse; minimum 2.
- LONG_CYCLES, 100000000, hold time for long-press clear (2 s); used only with LONG_PRESS_CLR_EN.

Ports:
- clk_50M  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- key_start_n  input  1  start/stop pushbutton, active-low, asynchronous to clk_50M
- key_lap_n  input  1  lap/reset pushbutton, active-low, asynchronous to clk_50M
- tick_100ms  output  1  one-cycle count enable to the 100 ms digit counter
- cnt_clr  output  1  one-cycle synchronous clear to all time counters
- lap_load  output  1  one-cycle strobe: lap registers capture live count
- disp_sel  output  1  0 = display live count, 1 = display lap registers
- running  output  1  high in RUN or LAP
- state  output  3  encoded FSM state, for debug LEDs

Behaviour:
- Interface: one clock, clk_50M; rst is synchronous and active-high.
- Reset: all outputs 0. State = IDLE, prescaler = 0, debounce counters = 0. Synchronizer flops and accepted key levels = 1 (released).
- Key path, per key:
  - 2-flop synchronizer.
  - Counter increments while synced level != accepted level, clears when equal.
  - On reaching DB_CYCLES-1, accepted level takes the synced level and the counter clears.
  - Press event = accepted level 1->0, registered one-cycle pulse. Release generates no event.
- Latency: a key held low from cycle N gives its press event at cycle N+2+DB_CYCLES (±1 for metastability). State, cnt_clr, lap_load and disp_sel update on the clock edge that samples the event.
- State encoding: IDLE=0, RUN=1, PAUSE=2, LAP=3.
- Transitions (start = start event, lap = lap event):
  - IDLE: start -> RUN; lap -> ignored.
  - RUN: start -> PAUSE; lap -> LAP with lap_load=1.
  - LAP: lap -> LAP with lap_load=1 (new split); start -> PAUSE.
  - PAUSE: start -> RUN; lap -> IDLE with cnt_clr=1.
- Simultaneous start and lap events in one cycle: start wins, lap event is discarded.
- disp_sel = 1 only in LAP. Leaving LAP by start returns the display to the live count.
- Prescaler (width ceil(log2(TICK_DIV))):
  - Increments only in RUN and LAP; holds in PAUSE, so the sub-100 ms fraction is preserved across a pause.
  - Forced to 0 in IDLE and in the cycle cnt_clr is issued.
  - When it equals TICK_DIV-1 while running: wraps to 0 and tick_100ms=1 in the next cycle.
  - Tick period is exactly TICK_DIV cycles. No tick is issued in the cycle the FSM leaves RUN/LAP.
- rst mid-operation: everything returns to the reset state on the next edge. No cnt_clr pulse is emitted, because downstream counters share rst.
- Pulses (tick_100ms, cnt_clr, lap_load) are never wider than one cycle. cnt_clr and lap_load are mutually exclusive.

Optional Feature:
- Macro: LONG_PRESS_CLR_EN.
- Defined:
  - A counter runs while the accepted key_lap_n level is 0, saturating at LONG_CYCLES.
  - On reaching LONG_CYCLES-1, in any state, FSM -> IDLE with cnt_clr=1, once per hold.
  - The short-press lap event for that press is still processed normally at press time.
- Undefined: no counter or logic is instantiated; a clear is possible only from PAUSE.

Test Plan (DB_CYCLES=4, TICK_DIV=10, LONG_CYCLES=40):
- rst=1 for 3 cycles, keys released -> all outputs 0, state=0, no tick over 50 cycles.
- key_start_n low 20 cycles -> state=1 about 6 cycles after press, running=1. tick_100ms pulses every 10 cycles, exactly one cycle wide.
- Glitch: key_lap_n low for 3 cycles then high -> no lap event, no lap_load, state unchanged.
- From RUN: lap press -> lap_load single pulse, state=3, disp_sel=1, ticks continue. Start press -> state=2, disp_sel=0, ticks stop with prescaler held at value p. Start again -> first tick after exactly 10-p cycles.
- From PAUSE: lap press -> cnt_clr single pulse, state=0. Both keys pressed in the same cycle from RUN -> state=2, no lap_load.
- LONG_PRESS_CLR_EN defined: in RUN, hold key_lap_n low 60 cycles -> lap_load at the event, then cnt_clr once at the 40-cycle mark, state=0. Macro undefined: no cnt_clr.
